// File: rtl/router_arbiter.sv
// router_arbiter: round-robin scheduler granting one node a single FRAME_LEN-bit
// frame on the bit-serial router, reporting done or abort per frame.
module router_arbiter #(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [1:0] dest0,
  input  logic [1:0] dest1,
  input  logic [1:0] dest2,
  input  logic [1:0] dest3,
  output logic [3:0] grant,
  output logic [1:0] sender,
  output logic [1:0] receiver,
  output logic       bus_active,
  output logic       done,
  output logic       abort
);
  localparam int CW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, XFER, RELEASE} state_t;
  state_t state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d, sender_q, sender_d, receiver_q, receiver_d;
  logic [3:0] grant_q, grant_d;
  logic [CW-1:0] count_q, count_d;
  logic bus_active_q, bus_active_d, done_q, done_d, abort_q, abort_d;
  logic [3:0][1:0] dest;
  logic found;
  logic [1:0] win, idx;
  assign dest = {dest3, dest2, dest1, dest0};
  // Scan from the farthest offset down so the node closest to rr_ptr wins last.
  always_comb begin
    found = 1'b0;
    win = rr_ptr_q;
    idx = rr_ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_ptr_q + 2'(i);
      if (req[idx] && dest[idx] != idx) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    sender_d = sender_q;
    receiver_d = receiver_q;
    grant_d = grant_q;
    count_d = count_q;
    bus_active_d = 1'b0;
    done_d = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = SETUP;
        grant_d = 4'b0001 << win;
        sender_d = win;
        receiver_d = dest[win];
        rr_ptr_d = win + 2'd1;
      end
      SETUP: begin
        state_d = XFER;
        count_d = '0;
        bus_active_d = 1'b1;
      end
      XFER: begin
        count_d = count_q + 1'b1;
        if (!req[sender_q] || count_q == CW'(FRAME_LEN - 1)) begin
          state_d = RELEASE;
          grant_d = 4'b0000;
          abort_d = !req[sender_q];
          done_d = req[sender_q];
        end else begin
          bus_active_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      sender_q <= '0;
      receiver_q <= '0;
      grant_q <= '0;
      count_q <= '0;
      bus_active_q <= 1'b0;
      done_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sender_q <= sender_d;
      receiver_q <= receiver_d;
      grant_q <= grant_d;
      count_q <= count_d;
      bus_active_q <= bus_active_d;
      done_q <= done_d;
      abort_q <= abort_d;
    end
  end
  assign grant = grant_q;
  assign sender = sender_q;
  assign receiver = receiver_q;
  assign bus_active = bus_active_q;
  assign done = done_q;
  assign abort = abort_q;
endmodule

// File: tb/tb_router_arbiter.sv
// tb_router_arbiter: directed scenario tasks for router_arbiter with FRAME_LEN=8.
module tb_router_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [1:0] dest0 = '0, dest1 = '0, dest2 = '0, dest3 = '0;
  logic [3:0] grant;
  logic [1:0] sender, receiver;
  logic bus_active, done, abort;
  int n_cmp = 0, n_err = 0, cyc = 0;
  router_arbiter #(.FRAME_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .dest0(dest0), .dest1(dest1), .dest2(dest2), .dest3(dest3),
    .grant(grant), .sender(sender), .receiver(receiver),
    .bus_active(bus_active), .done(done), .abort(abort)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({grant, sender, receiver, bus_active, done, abort} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0", {grant, sender, receiver, bus_active, done, abort});
    end
    do_reset();
  endtask
  task automatic test_single_frame();
    int n;
    do_reset();
    req = 4'b0010;
    dest1 = 2'd3;
    tick();
    n_cmp++;
    if (grant !== 4'b0010 || sender !== 2'd1 || receiver !== 2'd3 || bus_active !== 1'b0) begin
      n_err++;
      $display("FAIL single_grant: got g=%b s=%0d r=%0d ba=%b want g=0010 s=1 r=3 ba=0", grant, sender, receiver, bus_active);
    end
    tick();
    n = 0;
    for (int i = 0; i < 20 && bus_active === 1'b1; i++) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != 8) begin
      n_err++;
      $display("FAIL single_xfer_len: got %0d want 8", n);
    end
    n_cmp++;
    if (done !== 1'b1 || abort !== 1'b0 || grant !== 4'b0000) begin
      n_err++;
      $display("FAIL single_done: got done=%b abort=%b g=%b want 1 0 0000", done, abort, grant);
    end
    req = '0;
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL single_done_pulse: got %b want 0", done);
    end
  endtask
  task automatic test_round_robin();
    int last, k;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [1:0] rcv [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    dest0 = 2'd1; dest1 = 2'd2; dest2 = 2'd3; dest3 = 2'd0;
    req = 4'b1111;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 15 && grant === 4'b0000; i++) tick();
      k = order[g];
      n_cmp++;
      if (grant !== (4'b0001 << k) || receiver !== rcv[k]) begin
        n_err++;
        $display("FAIL rr_grant%0d: got g=%b r=%0d want g=%b r=%0d", g, grant, receiver, 4'b0001 << k, rcv[k]);
      end
      if (g > 0) begin
        n_cmp++;
        if (cyc - last != 11) begin
          n_err++;
          $display("FAIL rr_spacing%0d: got %0d want 11", g, cyc - last);
        end
      end
      last = cyc;
      for (int i = 0; i < 15 && done !== 1'b1; i++) tick();
      n_cmp++;
      if (done !== 1'b1 || abort !== 1'b0) begin
        n_err++;
        $display("FAIL rr_done%0d: got done=%b abort=%b want 1 0", g, done, abort);
      end
    end
    req = '0;
    tick();
    tick();
  endtask
  task automatic test_self_address();
    do_reset();
    dest2 = 2'd2;
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({grant, bus_active, done, abort} !== 7'd0) begin
        n_err++;
        $display("FAIL self_idle%0d: got %b want 0", i, {grant, bus_active, done, abort});
      end
    end
    dest2 = 2'd0;
    tick();
    n_cmp++;
    if (grant !== 4'b0100 || sender !== 2'd2 || receiver !== 2'd0) begin
      n_err++;
      $display("FAIL self_fixed: got g=%b s=%0d r=%0d want 0100 2 0", grant, sender, receiver);
    end
  endtask
  task automatic test_abort();
    do_reset();
    dest0 = 2'd2; dest1 = 2'd0;
    req = 4'b0011;
    tick();
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_err++;
      $display("FAIL abort_grant0: got %b want 0001", grant);
    end
    for (int i = 0; i < 4; i++) tick();
    req = 4'b0010;
    tick();
    n_cmp++;
    if (abort !== 1'b1 || done !== 1'b0 || bus_active !== 1'b0 || grant !== 4'b0000) begin
      n_err++;
      $display("FAIL abort_pulse: got abort=%b done=%b ba=%b g=%b want 1 0 0 0000", abort, done, bus_active, grant);
    end
    tick();
    n_cmp++;
    if (abort !== 1'b0) begin
      n_err++;
      $display("FAIL abort_width: got %b want 0", abort);
    end
    tick();
    n_cmp++;
    if (grant !== 4'b0010 || sender !== 2'd1 || receiver !== 2'd0) begin
      n_err++;
      $display("FAIL abort_next: got g=%b s=%0d r=%0d want 0010 1 0", grant, sender, receiver);
    end
  endtask
  task automatic test_mid_frame_changes();
    do_reset();
    dest0 = 2'd3;
    req = 4'b0001;
    tick();
    tick();
    dest0 = 2'd1; dest1 = 2'd0; dest2 = 2'd0; dest3 = 2'd0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (grant !== 4'b0001 || sender !== 2'd0 || receiver !== 2'd3 || bus_active !== 1'b1) begin
        n_err++;
        $display("FAIL hold%0d: got g=%b s=%0d r=%0d ba=%b want 0001 0 3 1", i, grant, sender, receiver, bus_active);
      end
    end
    for (int i = 0; i < 15 && done !== 1'b1; i++) tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL hold_done: got %b want 1", done);
    end
    tick();
    tick();
    n_cmp++;
    if (grant !== 4'b0010 || receiver !== 2'd0) begin
      n_err++;
      $display("FAIL hold_next: got g=%b r=%0d want 0010 0", grant, receiver);
    end
  endtask
  task automatic test_reset_mid_frame();
    do_reset();
    dest2 = 2'd1;
    req = 4'b0100;
    tick();
    tick();
    tick();
    n_cmp++;
    if (bus_active !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_xfer: got ba=%b want 1", bus_active);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({grant, sender, receiver, bus_active, done, abort} !== 11'd0) begin
      n_err++;
      $display("FAIL rstmid_async: got %b want 0", {grant, sender, receiver, bus_active, done, abort});
    end
    tick();
    n_cmp++;
    if ({grant, bus_active, done, abort} !== 7'd0) begin
      n_err++;
      $display("FAIL rstmid_hold: got %b want 0", {grant, bus_active, done, abort});
    end
    dest0 = 2'd1; dest1 = 2'd2; dest2 = 2'd3; dest3 = 2'd0;
    req = 4'b1111;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (grant !== 4'b0001 || receiver !== 2'd1) begin
      n_err++;
      $display("FAIL rstmid_ptr: got g=%b r=%0d want 0001 1", grant, receiver);
    end
  endtask
  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_self_address();
    test_abort();
    test_mid_frame_changes();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
